// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU/register-file sequencer.
// Instruction layout: op[15:12] rdest[11:8] ext[7:4] rsrc[3:0]; imm8 = [7:0].
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WRITE  = 2'd3
   } seq_state_e;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int EXT_MSB = 7;
   localparam int EXT_LSB = 4;
   localparam int RS_MSB  = 3;
   localparam int RS_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_REG  = 4'h0;
   localparam logic [3:0] ALU_CMP = 4'hB;

   // Flag vector is packed {C,L,F,Z,N}
   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_L = 3;
   localparam int FLAG_C = 4;
   localparam int FLAG_W = 5;

   function automatic logic [15:0] sign_ext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-bit register index to 16-bit one-hot write enable; all-zero when disabled.
module reg_onehot_dec (
   input  logic [3:0]  idx_i,
   input  logic        en_i,
   output logic [15:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Four-phase sequencer: accepts one instruction, drives ALU/regfile selects,
// then issues a single one-hot register write and retires it.
//
// state     | meaning
// ST_IDLE   | ready for a new instruction
// ST_DECODE | selects driven from the latched instruction
// ST_EXEC   | ALU settling; flags_in captured into pending flags
// ST_WRITE  | regEnable/done asserted, flags committed on exit
module alu_reg_sequencer
   import alu_seq_pkg::*;
#(
   parameter logic [3:0] CMP_OP = ALU_CMP,
   parameter int         CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [4:0]        flags_in,
   output logic [3:0]        muxA_sel,
   output logic [3:0]        muxB_sel,
   output logic              imm_sel,
   output logic [15:0]       imm,
   output logic [3:0]        alu_op,
   output logic [15:0]       regEnable,
   output logic [4:0]        flags,
   output logic              done,
   output logic [CNT_W-1:0]  retired
);

   seq_state_e        state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic [FLAG_W-1:0] pend_q, pend_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic              is_reg_form;
   logic              wr_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         pend_q    <= '0;
         flags_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         pend_q    <= pend_d;
         flags_q   <= flags_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      pend_d    = pend_q;
      flags_d   = flags_q;
      retired_d = retired_q;
      unique case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            pend_d    = flags_in;
            // Counted on entry to WRITE so the new total is visible alongside done
            retired_d = retired_q + CNT_W'(1);
            state_d   = ST_WRITE;
         end
         ST_WRITE: begin
            flags_d = pend_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Selects decode straight from the instruction register, which only loads in IDLE
   assign is_reg_form = (instr_q[OP_MSB:OP_LSB] == OP_REG);
   assign muxA_sel    = instr_q[RD_MSB:RD_LSB];
   assign muxB_sel    = instr_q[RS_MSB:RS_LSB];
   assign imm_sel     = ~is_reg_form;
   assign alu_op      = is_reg_form ? instr_q[EXT_MSB:EXT_LSB] : instr_q[OP_MSB:OP_LSB];
   assign imm         = is_reg_form ? 16'h0000 : sign_ext8(instr_q[IMM_MSB:IMM_LSB]);

   assign wr_en = (state_q == ST_WRITE) && (alu_op != CMP_OP);

   reg_onehot_dec u_wr_dec (
      .idx_i    (instr_q[RD_MSB:RD_LSB]),
      .en_i     (wr_en),
      .onehot_o (regEnable)
   );

   assign instr_ready = (state_q == ST_IDLE);
   assign done        = (state_q == ST_WRITE);
   assign flags       = flags_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer; counter narrowed to 4 bits so wrap is reachable.
module tb_alu_reg_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  flags_in;
   logic [3:0]  muxA_sel, muxB_sel, alu_op;
   logic        imm_sel, done;
   logic [15:0] imm, regEnable;
   logic [4:0]  flags;
   logic [3:0]  retired;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [3:0]  exp_ret;

   always #5 clk = ~clk;

   alu_reg_sequencer #(.CMP_OP(4'hB), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .flags_in    (flags_in),
      .muxA_sel    (muxA_sel),
      .muxB_sel    (muxB_sel),
      .imm_sel     (imm_sel),
      .imm         (imm),
      .alu_op      (alu_op),
      .regEnable   (regEnable),
      .flags       (flags),
      .done        (done),
      .retired     (retired)
   );

   // Waits for IDLE, presents ins for exactly one accept edge; returns just after it.
   task automatic accept(input logic [15:0] ins);
      int n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         tests_run++; tests_failed++;
         $display("FAIL accept_timeout ready=%b required=1", instr_ready);
      end
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] seen;
      reset = 1'b1; instr_valid = 1'b0; instr = '0; flags_in = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({regEnable, done, flags, retired, muxA_sel, muxB_sel, imm_sel, imm, alu_op} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs got regEn=%h done=%b flags=%b ret=%0d a=%h b=%h isel=%b imm=%h op=%h required all 0",
                  regEnable, done, flags, retired, muxA_sel, muxB_sel, imm_sel, imm, alu_op);
      end
      tests_run++;
      if (instr_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_ready got %b required 1", instr_ready);
      end
      // Retire one so the second reset has a nonzero counter to clear
      accept(16'h0100);
      repeat (3) @(negedge clk);
      tests_run++;
      if (retired !== 4'd1) begin
         tests_failed++; $display("FAIL pre_reset_retired got %0d required 1", retired);
      end
      // Reset arriving mid-EXEC must discard the instruction
      accept(16'h0351);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      seen = '0;
      @(posedge clk);
      @(negedge clk);
      seen = seen | regEnable;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({regEnable, done, flags, retired, muxA_sel, muxB_sel, imm_sel, imm, alu_op} !== '0) begin
         tests_failed++;
         $display("FAIL midexec_reset_outputs got regEn=%h done=%b flags=%b ret=%0d a=%h b=%h isel=%b imm=%h op=%h required all 0",
                  regEnable, done, flags, retired, muxA_sel, muxB_sel, imm_sel, imm, alu_op);
      end
      tests_run++;
      if (instr_ready !== 1'b1) begin
         tests_failed++; $display("FAIL midexec_reset_ready got %b required 1", instr_ready);
      end
      repeat (4) begin
         @(negedge clk);
         seen = seen | regEnable;
      end
      tests_run++;
      if (seen !== 16'h0000) begin
         tests_failed++; $display("FAIL midexec_reset_nowrite got %h required 0000", seen);
      end
      exp_ret = 4'd0;
   endtask

   task automatic test_reg_add();
      accept(16'h0351);
      @(negedge clk);
      tests_run++;
      if ({muxA_sel, muxB_sel, imm_sel, alu_op} !== {4'd3, 4'd1, 1'b0, 4'd5}) begin
         tests_failed++;
         $display("FAIL add_decode got a=%h b=%h isel=%b op=%h required a=3 b=1 isel=0 op=5",
                  muxA_sel, muxB_sel, imm_sel, alu_op);
      end
      tests_run++;
      if (regEnable !== 16'h0000) begin
         tests_failed++; $display("FAIL add_decode_regen got %h required 0000", regEnable);
      end
      @(negedge clk);
      @(negedge clk);
      exp_ret = exp_ret + 4'd1;
      tests_run++;
      if ({regEnable, done, retired} !== {16'h0008, 1'b1, exp_ret}) begin
         tests_failed++;
         $display("FAIL add_write got regEn=%h done=%b ret=%0d required 0008 1 %0d",
                  regEnable, done, retired, exp_ret);
      end
      tests_run++;
      if ({muxA_sel, muxB_sel, alu_op} !== {4'd3, 4'd1, 4'd5}) begin
         tests_failed++; $display("FAIL add_hold got a=%h b=%h op=%h required 3 1 5", muxA_sel, muxB_sel, alu_op);
      end
      @(negedge clk);
      tests_run++;
      if ({regEnable, done, instr_ready} !== {16'h0000, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL add_after got regEn=%h done=%b ready=%b required 0000 0 1", regEnable, done, instr_ready);
      end
   endtask

   task automatic test_imm();
      accept(16'h5AF0);
      @(negedge clk);
      tests_run++;
      if ({imm, imm_sel, alu_op, muxA_sel, muxB_sel} !== {16'hFFF0, 1'b1, 4'd5, 4'hA, 4'h0}) begin
         tests_failed++;
         $display("FAIL imm_decode got imm=%h isel=%b op=%h a=%h b=%h required FFF0 1 5 A 0",
                  imm, imm_sel, alu_op, muxA_sel, muxB_sel);
      end
      @(negedge clk);
      @(negedge clk);
      exp_ret = exp_ret + 4'd1;
      tests_run++;
      if ({regEnable, done, retired, imm} !== {16'h0400, 1'b1, exp_ret, 16'hFFF0}) begin
         tests_failed++;
         $display("FAIL imm_write got regEn=%h done=%b ret=%0d imm=%h required 0400 1 %0d FFF0",
                  regEnable, done, retired, imm, exp_ret);
      end
   endtask

   task automatic test_cmp();
      logic [15:0] seen;
      accept(16'h0EB2);
      @(negedge clk);
      seen = regEnable;
      tests_run++;
      if ({alu_op, imm_sel, muxA_sel, muxB_sel} !== {4'hB, 1'b0, 4'hE, 4'h2}) begin
         tests_failed++;
         $display("FAIL cmp_decode got op=%h isel=%b a=%h b=%h required B 0 E 2", alu_op, imm_sel, muxA_sel, muxB_sel);
      end
      @(negedge clk);
      flags_in = 5'b00010;
      seen = seen | regEnable;
      @(negedge clk);
      flags_in = 5'b00000;
      seen = seen | regEnable;
      exp_ret = exp_ret + 4'd1;
      tests_run++;
      if ({done, retired, flags} !== {1'b1, exp_ret, 5'b00000}) begin
         tests_failed++;
         $display("FAIL cmp_write got done=%b ret=%0d flags=%b required 1 %0d 00000", done, retired, flags, exp_ret);
      end
      @(negedge clk);
      seen = seen | regEnable;
      tests_run++;
      if (flags !== 5'b00010) begin
         tests_failed++; $display("FAIL cmp_flags got %b required 00010", flags);
      end
      tests_run++;
      if (seen !== 16'h0000) begin
         tests_failed++; $display("FAIL cmp_nowrite got %h required 0000", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_en;
      logic        exp_rdy;
      @(negedge clk);
      instr = 16'h0F12;
      instr_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         exp_en  = (i == 2) ? 16'h8000 : (i == 6) ? 16'h0001 : 16'h0000;
         exp_rdy = (i == 3);
         tests_run++;
         if ({regEnable, instr_ready} !== {exp_en, exp_rdy}) begin
            tests_failed++;
            $display("FAIL b2b_cycle%0d got regEn=%h ready=%b required %h %b", i, regEnable, instr_ready, exp_en, exp_rdy);
         end
         if (i == 0) instr = 16'h0012;
         if (i == 1) begin
            tests_run++;
            if (muxA_sel !== 4'hF) begin
               tests_failed++; $display("FAIL b2b_ignore_instr got a=%h required F", muxA_sel);
            end
         end
         if (i == 4) instr_valid = 1'b0;
      end
      exp_ret = exp_ret + 4'd2;
      tests_run++;
      if (retired !== exp_ret) begin
         tests_failed++; $display("FAIL b2b_retired got %0d required %0d", retired, exp_ret);
      end
   endtask

   task automatic test_counter_wrap();
      int n;
      n = 16 - int'(exp_ret);
      for (int i = 0; i < n; i++) begin
         accept(16'h0100);
         repeat (3) @(negedge clk);
         exp_ret = exp_ret + 4'd1;
      end
      tests_run++;
      if (retired !== 4'd0) begin
         tests_failed++; $display("FAIL wrap_zero got %0d required 0", retired);
      end
      accept(16'h0100);
      repeat (3) @(negedge clk);
      tests_run++;
      if (retired !== 4'd1) begin
         tests_failed++; $display("FAIL wrap_after got %0d required 1", retired);
      end
   endtask

   initial begin
      exp_ret = 4'd0;
      test_reset();
      test_reg_add();
      test_imm();
      test_cmp();
      test_back_to_back();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
